// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared encodings for the load/store sequencer: access size
//                codes, FSM state enum and the size-to-byte-mask helper.
//                The ISSUE1/WAIT1 states are only reachable when
//                LSU_MISALIGN_SPLIT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_e;

    // Byte-enable pattern of an access before it is shifted to its lane.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl_if
//  Description : Request/response and data-memory bus bundle of the
//                load/store sequencer. The slave modport is the sequencer's
//                view; the master modport is the execute stage + memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_align
//  Description : Combinational load-data aligner. Shifts the two captured
//                beats {hi, lo} right by the byte offset, truncates to the
//                access size and sign- or zero-extends to 32 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  wire logic [63:0] i_data,
    input  wire logic [1:0]  i_offset,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    output logic      [31:0] o_data
);

    logic [31:0] w_win;

    // Select the addressed window and extend it to a full word.
    always_comb begin
        w_win  = 32'(i_data >> {i_offset, 3'b000});
        o_data = w_win;
        case (i_size)
            SZ_BYTE: o_data = i_unsigned ? {24'b0, w_win[7:0]}
                                         : {{24{w_win[7]}}, w_win[7:0]};
            SZ_HALF: o_data = i_unsigned ? {16'b0, w_win[15:0]}
                                         : {{16{w_win[15]}}, w_win[15:0]};
            default: o_data = w_win;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store sequencer between execute and the data-memory
//                port. One request in flight; word-aligned bus beats with
//                byte enables; extended load data on completion.
//                Build option LSU_MISALIGN_SPLIT_EN: when defined, accesses
//                crossing a word boundary are split into two beats; when
//                undefined they complete with rsp_err and no bus activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    lsu_ctrl_if.slave  bus
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              r_req_ready;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_off;
    logic              r_err;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_lo;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0]       r_hi;
    logic              r_split;
`endif

    logic        w_accept;
    logic        w_cross;
    logic        w_bad;
    logic [7:0]  w_mask8;
    logic [63:0] w_wdata64;
    logic [63:0] w_ld_beats;
    logic [31:0] w_ld_data;

    assign w_accept = bus.req_valid & r_req_ready;

    // Does the incoming access straddle a word boundary?
    assign w_cross = ((bus.req_size == SZ_HALF) && (bus.req_addr[1:0] == 2'b11)) ||
                     ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_bad      = (bus.req_size == SZ_ILL);
    assign w_ld_beats = {r_hi, r_lo};
`else
    assign w_bad      = (bus.req_size == SZ_ILL) | w_cross;
    assign w_ld_beats = {32'b0, r_lo};
`endif

    // Lane placement of both beats, derived only from latched request state.
    assign w_mask8   = {4'b0000, size_mask(r_size)} << r_off;
    assign w_wdata64 = {32'b0, r_wdata} << {r_off, 3'b000};

    lsu_load_align u_load_align (
        .i_data     (w_ld_beats),
        .i_offset   (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ld_data)
    );

    // State register plus registered request-ready (low while in reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == ST_IDLE);
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = w_bad ? ST_RESP : ST_ISSUE0;
            ST_ISSUE0: if (bus.mem_gnt) w_next = ST_WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_WAIT0:  if (bus.mem_rvalid) w_next = r_split ? ST_ISSUE1 : ST_RESP;
            ST_ISSUE1: if (bus.mem_gnt) w_next = ST_WAIT1;
            ST_WAIT1:  if (bus.mem_rvalid) w_next = ST_RESP;
`else
            ST_WAIT0:  if (bus.mem_rvalid) w_next = ST_RESP;
`endif
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Request latches and captured read beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_err      <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= 32'b0;
            r_lo       <= 32'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_hi       <= 32'b0;
            r_split    <= 1'b0;
`endif
        end else begin
            if ((r_state == ST_IDLE) && w_accept) begin
                r_we       <= bus.req_we;
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_off      <= bus.req_addr[1:0];
                r_err      <= w_bad;
                r_waddr    <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                r_wdata    <= bus.req_wdata;
                r_lo       <= 32'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                r_hi       <= 32'b0;
                r_split    <= w_cross;
`endif
            end
            if ((r_state == ST_WAIT0) && bus.mem_rvalid) begin
                r_lo <= bus.mem_rdata;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if ((r_state == ST_WAIT1) && bus.mem_rvalid) begin
                r_hi <= bus.mem_rdata;
            end
`endif
        end
    end

    // Bus and response outputs decoded from state and latched request.
    always_comb begin
        bus.req_ready = r_req_ready;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = 32'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = 32'b0;
        case (r_state)
            ST_ISSUE0: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = r_waddr;
                bus.mem_we    = r_we;
                bus.mem_be    = w_mask8[3:0];
                bus.mem_wdata = w_wdata64[31:0];
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ISSUE1: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = r_waddr + ADDR_W'(4);
                bus.mem_we    = r_we;
                bus.mem_be    = w_mask8[7:4];
                bus.mem_wdata = w_wdata64[63:32];
            end
`endif
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = r_err;
                bus.rsp_rdata = (r_err || r_we) ? 32'b0 : w_ld_data;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Directed self-checking bench for lsu_ctrl. Expectations
//                that depend on LSU_MISALIGN_SPLIT_EN follow the same macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lsu_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request and play a memory that answers each beat with d0/d1.
    task automatic run_op(
        input  logic        we,
        input  logic [1:0]  sz,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  logic [31:0] d0,
        input  logic [31:0] d1,
        input  int          gwait,
        output int          lat,
        output int          nb,
        output logic [31:0] a0,
        output logic [31:0] a1,
        output logic [3:0]  b0,
        output logic [3:0]  b1,
        output logic [31:0] w0,
        output logic [31:0] w1,
        output logic        we0,
        output logic [31:0] rd,
        output logic        er,
        output logic        stab
    );
        int   cnt;
        int   waitc;
        logic pend;
        logic done;
        logic held;
        cnt = 0;
        while (!bus.req_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'b0;
        lat = 0; nb = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; w0 = 0; w1 = 0;
        we0 = 0; rd = 32'hxxxxxxxx; er = 1'bx; stab = 1'b1;
        waitc = gwait; pend = 0; done = 0; held = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (bus.rsp_valid) begin
                lat  = k + 1;
                rd   = bus.rsp_rdata;
                er   = bus.rsp_err;
                done = 1'b1;
            end else begin
                if (pend) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = (nb == 1) ? d0 : d1;
                    pend = 1'b0;
                end
                if (bus.mem_req) begin
                    if (nb == 0) begin
                        if (held && (bus.mem_addr !== a0 || bus.mem_be !== b0 ||
                                     bus.mem_wdata !== w0 || bus.mem_we !== we0))
                            stab = 1'b0;
                        a0 = bus.mem_addr; b0 = bus.mem_be;
                        w0 = bus.mem_wdata; we0 = bus.mem_we;
                        held = 1'b1;
                    end else begin
                        a1 = bus.mem_addr; b1 = bus.mem_be; w1 = bus.mem_wdata;
                    end
                    if (waitc > 0) begin
                        waitc--;
                    end else begin
                        bus.mem_gnt = 1'b1;
                        nb++;
                        pend = 1'b1;
                    end
                end
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: no rsp_valid within 40 cycles (addr %h)", addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready);
        end
        checks++;
        if ({bus.mem_req, bus.rsp_valid, bus.rsp_err, bus.mem_we, bus.mem_be} !== 8'h00 ||
            bus.mem_addr !== 32'h0 || bus.rsp_rdata !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: got req=%b rsp=%b be=%b expected all 0",
                               bus.mem_req, bus.rsp_valid, bus.mem_be);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_load_word();
        int lat, nb; logic [31:0] a0, a1, w0, w1, rd; logic [3:0] b0, b1; logic we0, er, st;
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0,
               lat, nb, a0, a1, b0, b1, w0, w1, we0, rd, er, st);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", lat); end
        checks++; if (b0 !== 4'b1111 || a0 !== 32'h100 || we0 !== 1'b0 || nb !== 1) begin
            errors++; $display("FAIL lw_bus: got be=%b addr=%h we=%b beats=%0d expected 1111 100 0 1", b0, a0, we0, nb); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", er); end
    endtask

    task automatic test_load_byte();
        int lat, nb; logic [31:0] a0, a1, w0, w1, rd; logic [3:0] b0, b1; logic we0, er, st;
        run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000, 32'h0, 0,
               lat, nb, a0, a1, b0, b1, w0, w1, we0, rd, er, st);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h expected ffffff80", rd); end
        checks++; if (b0 !== 4'b1000 || a0 !== 32'h100) begin
            errors++; $display("FAIL lb_be: got be=%b addr=%h expected 1000 100", b0, a0); end
        run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000, 32'h0, 0,
               lat, nb, a0, a1, b0, b1, w0, w1, we0, rd, er, st);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", rd); end
        run_op(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h12F0E134, 32'h0, 0,
               lat, nb, a0, a1, b0, b1, w0, w1, we0, rd, er, st);
        checks++; if (rd !== 32'hFFFFF0E1 || b0 !== 4'b0110 || er !== 1'b0) begin
            errors++; $display("FAIL lh_inword: got data=%h be=%b err=%b expected fffff0e1 0110 0", rd, b0, er); end
    endtask

    task automatic test_store_half();
        int lat, nb; logic [31:0] a0, a1, w0, w1, rd; logic [3:0] b0, b1; logic we0, er, st;
        run_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h55555555, 32'h0, 0,
               lat, nb, a0, a1, b0, b1, w0, w1, we0, rd, er, st);
        checks++; if (b0 !== 4'b1100 || w0 !== 32'hABCD0000 || we0 !== 1'b1) begin
            errors++; $display("FAIL sh_bus: got be=%b wdata=%h we=%b expected 1100 abcd0000 1", b0, w0, we0); end
        checks++; if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL sh_rsp: got rdata=%h err=%b lat=%0d expected 0 0 3", rd, er, lat); end
    endtask

    task automatic test_misaligned();
        int lat, nb; logic [31:0] a0, a1, w0, w1, rd; logic [3:0] b0, b1; logic we0, er, st;
        run_op(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h44332211, 32'h88776655, 0,
               lat, nb, a0, a1, b0, b1, w0, w1, we0, rd, er, st);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (a0 !== 32'h100 || a1 !== 32'h104 || b0 !== 4'b1110 || b1 !== 4'b0001 || nb !== 2) begin
            errors++; $display("FAIL lw_split_bus: got %h/%b %h/%b beats=%0d expected 100/1110 104/0001 2", a0, b0, a1, b1, nb); end
        checks++; if (rd !== 32'h55443322 || er !== 1'b0 || lat !== 5) begin
            errors++; $display("FAIL lw_split_rsp: got data=%h err=%b lat=%0d expected 55443322 0 5", rd, er, lat); end
`else
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nb !== 0) begin
            errors++; $display("FAIL lw_mis_reject: got err=%b data=%h lat=%0d beats=%0d expected 1 0 1 0", er, rd, lat, nb); end
`endif
        run_op(1'b1, 2'b10, 1'b0, 32'h103, 32'h11223344, 32'h0, 32'h0, 0,
               lat, nb, a0, a1, b0, b1, w0, w1, we0, rd, er, st);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (w0 !== 32'h44000000 || w1 !== 32'h00112233 || b0 !== 4'b1000 || b1 !== 4'b0111) begin
            errors++; $display("FAIL sw_split: got %h/%b %h/%b expected 44000000/1000 00112233/0111", w0, b0, w1, b1); end
`else
        checks++; if (er !== 1'b1 || nb !== 0) begin
            errors++; $display("FAIL sw_mis_reject: got err=%b beats=%0d expected 1 0", er, nb); end
`endif
    endtask

    task automatic test_illegal_and_stall();
        int lat, nb; logic [31:0] a0, a1, w0, w1, rd; logic [3:0] b0, b1; logic we0, er, st;
        run_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h12345678, 32'h0, 0,
               lat, nb, a0, a1, b0, b1, w0, w1, we0, rd, er, st);
        checks++; if (er !== 1'b1 || lat !== 1 || nb !== 0 || rd !== 32'h0) begin
            errors++; $display("FAIL size11: got err=%b lat=%0d beats=%0d data=%h expected 1 1 0 0", er, lat, nb, rd); end
        run_op(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 32'h0, 5,
               lat, nb, a0, a1, b0, b1, w0, w1, we0, rd, er, st);
        checks++; if (st !== 1'b1 || a0 !== 32'h200 || b0 !== 4'b1111) begin
            errors++; $display("FAIL gnt_stall_stable: got stable=%b addr=%h be=%b expected 1 200 1111", st, a0, b0); end
        checks++; if (lat !== 8 || rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL gnt_stall_rsp: got lat=%0d data=%h expected 8 cafef00d", lat, rd); end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h300;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_gnt   = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_clear: got req=%b ready=%b rsp=%b expected 0 0 0",
                               bus.mem_req, bus.req_ready, bus.rsp_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h99999999;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_stale_rvalid: got rsp_seen=%b ready=%b expected 0 1", seen, bus.req_ready); end
    endtask

    initial begin
        checks = 0; errors = 0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_illegal_and_stall();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
